// File: rtl/decode_pkg.sv
// Shared decode constants and the registered control-word layout for the ID/EX stage.
// Opcodes, ALU codes and extender selects live here so the decoder and pipe agree.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b100001;
  localparam logic [5:0] OP_BEQ   = 6'b100010;
  localparam logic [5:0] OP_BNE   = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b100100;
  localparam logic [5:0] OP_ANDI  = 6'b100101;
  localparam logic [5:0] OP_ORI   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_JTYPE = 6'b000000;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [5:0] MUL_FUN  = 6'b000110;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;
  localparam logic [1:0] EXT_JUMP = 2'b11;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       branch_ne;
    logic       reg_we;
    logic       alu_src;
    logic       mem_we;
    logic       mem_re;
    logic       result_src;
    logic       illegal;
    logic [1:0] ext_sel;
  } ctrl_word_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational opcode/fun decode to control word, destination and source-use flags.
// Zero latency; no flow control.
module decode_ctrl_comb
  import decode_pkg::*;
#(
  parameter int RW   = 5,
  parameter int ALUW = 4
) (
  input  logic [5:0]      opcode,
  input  logic [5:0]      fun,
  input  logic [RW-1:0]   rt,
  input  logic [RW-1:0]   rd,
  output ctrl_word_t      ctrl,
  output logic [ALUW-1:0] alu_ctrl,
  output logic [RW-1:0]   dest,
  output logic            use_rs,
  output logic            use_rt,
  output logic            is_mul
);

  always_comb begin
    ctrl     = '0;
    alu_ctrl = '0;
    dest     = '0;
    use_rs   = 1'b1;
    use_rt   = 1'b0;
    is_mul   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_we = 1'b1;
        alu_ctrl    = fun[ALUW-1:0];
        dest        = rd;
        use_rt      = 1'b1;
        is_mul      = (fun == MUL_FUN);
      end
      OP_LW: begin
        ctrl.reg_we     = 1'b1;
        ctrl.ext_sel    = EXT_SIGN;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_re     = 1'b1;
        ctrl.result_src = 1'b1;
        alu_ctrl        = ALUW'(ALU_ADD);
        dest            = rt;
      end
      OP_SW: begin
        ctrl.ext_sel = EXT_SIGN;
        ctrl.alu_src = 1'b1;
        ctrl.mem_we  = 1'b1;
        alu_ctrl     = ALUW'(ALU_ADD);
        use_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (opcode == OP_BNE);
        ctrl.ext_sel   = EXT_SIGN;
        alu_ctrl       = ALUW'(ALU_SUB);
        use_rt         = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.ext_sel = EXT_SIGN;
        ctrl.alu_src = 1'b1;
        alu_ctrl     = (opcode == OP_SLTI) ? ALUW'(ALU_SLT) : ALUW'(ALU_ADD);
        dest         = rt;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.ext_sel = EXT_ZERO;
        ctrl.alu_src = 1'b1;
        alu_ctrl     = (opcode == OP_ORI) ? ALUW'(ALU_OR) : ALUW'(ALU_AND);
        dest         = rt;
      end
      OP_JTYPE: begin
        ctrl.jump    = 1'b1;
        ctrl.ext_sel = EXT_JUMP;
        use_rs       = 1'b0;
      end
      OP_NOP: begin
        use_rs = 1'b0;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    // Writes to register 0 are architecturally discarded, so never request them.
    if (dest == '0) ctrl.reg_we = 1'b0;
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID/EX control register with load-use interlock and multi-cycle multiply issue blocking; 1-cycle latency.
// Backpressure: holds the word while out_ready is low and drops in_ready on hazard, busy multiply or flush.
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int RW       = 5,
  parameter int ALUW     = 4,
  parameter int MUL_LAT  = 3,
  parameter int LOAD_GAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      fun,
  input  logic [RW-1:0]   rs,
  input  logic [RW-1:0]   rt,
  input  logic [RW-1:0]   rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            jump,
  output logic            branch,
  output logic            branch_ne,
  output logic            reg_we,
  output logic            alu_src,
  output logic            mem_we,
  output logic            mem_re,
  output logic            result_src,
  output logic            illegal,
  output logic [1:0]      ext_sel,
  output logic [ALUW-1:0] alu_ctrl,
  output logic [RW-1:0]   dest_reg
);

  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam int LCW = $clog2(LOAD_GAP + 2);

  ctrl_word_t      dec_ctrl;
  ctrl_word_t      q_ctrl;
  logic [ALUW-1:0] dec_alu;
  logic [RW-1:0]   dec_dest;
  logic            use_rs, use_rt, is_mul;

  logic [MCW-1:0]  mul_cnt;
  logic [LCW-1:0]  ld_cnt;
  logic [RW-1:0]   ld_dest;
  logic            ld_pend, rs_hit, rt_hit, hazard, accept, out_fire;

  decode_ctrl_comb #(.RW(RW), .ALUW(ALUW)) u_dec (
    .opcode   (opcode),
    .fun      (fun),
    .rt       (rt),
    .rd       (rd),
    .ctrl     (dec_ctrl),
    .alu_ctrl (dec_alu),
    .dest     (dec_dest),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .is_mul   (is_mul)
  );

  // A load is hazardous both while it sits here and for LOAD_GAP cycles after it leaves.
  assign ld_pend  = (ld_cnt != '0);
  assign rs_hit   = (rs != '0) && ((out_valid && q_ctrl.mem_re && rs == dest_reg) ||
                                   (ld_pend && rs == ld_dest));
  assign rt_hit   = (rt != '0) && ((out_valid && q_ctrl.mem_re && rt == dest_reg) ||
                                   (ld_pend && rt == ld_dest));
  assign hazard   = (use_rs && rs_hit) || (use_rt && rt_hit);

  assign in_ready = !rst && !flush && (mul_cnt == '0) && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q_ctrl    <= '0;
      alu_ctrl  <= '0;
      dest_reg  <= '0;
      mul_cnt   <= '0;
      ld_cnt    <= '0;
      ld_dest   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        q_ctrl    <= dec_ctrl;
        alu_ctrl  <= dec_alu;
        dest_reg  <= dec_dest;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (flush)                mul_cnt <= '0;
      else if (accept && is_mul) mul_cnt <= MCW'(MUL_LAT - 1);
      else if (mul_cnt != '0)   mul_cnt <= mul_cnt - MCW'(1);

      if (flush) begin
        ld_cnt <= '0;
      end else if (out_fire && q_ctrl.mem_re) begin
        ld_cnt  <= LCW'(LOAD_GAP);
        ld_dest <= dest_reg;
      end else if (ld_pend) begin
        ld_cnt <= ld_cnt - LCW'(1);
      end
    end
  end

  assign jump       = q_ctrl.jump;
  assign branch     = q_ctrl.branch;
  assign branch_ne  = q_ctrl.branch_ne;
  assign reg_we     = q_ctrl.reg_we;
  assign alu_src    = q_ctrl.alu_src;
  assign mem_we     = q_ctrl.mem_we;
  assign mem_re     = q_ctrl.mem_re;
  assign result_src = q_ctrl.result_src;
  assign illegal    = q_ctrl.illegal;
  assign ext_sel    = q_ctrl.ext_sel;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: decode table vectors, interlock/hold/flush sequences, and a
// randomized run against a timestamp-based reference model.
module tb_decode_ctrl_pipe;

  localparam int RW = 5, ALUW = 4, MUL_LAT = 3, LOAD_GAP = 1;

  logic            clk = 1'b0;
  logic            rst, in_valid, flush, out_ready;
  logic [5:0]      opcode, fun;
  logic [RW-1:0]   rs, rt, rd;
  logic            in_ready, out_valid;
  logic            jump, branch, branch_ne, reg_we, alu_src, mem_we, mem_re, result_src, illegal;
  logic [1:0]      ext_sel;
  logic [ALUW-1:0] alu_ctrl;
  logic [RW-1:0]   dest_reg;
  logic [19:0]     dut_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.RW(RW), .ALUW(ALUW), .MUL_LAT(MUL_LAT), .LOAD_GAP(LOAD_GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .fun(fun), .rs(rs), .rt(rt), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .jump(jump), .branch(branch), .branch_ne(branch_ne), .reg_we(reg_we),
    .alu_src(alu_src), .mem_we(mem_we), .mem_re(mem_re), .result_src(result_src),
    .illegal(illegal), .ext_sel(ext_sel), .alu_ctrl(alu_ctrl), .dest_reg(dest_reg)
  );

  // Layout: jump,branch,bne,reg_we,alu_src,mem_we,mem_re,result_src,illegal,ext[2],alu[4],dest[5]
  assign dut_word = {jump, branch, branch_ne, reg_we, alu_src, mem_we, mem_re, result_src,
                     illegal, ext_sel, alu_ctrl, dest_reg};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic j, b, bn, we, src, mw, mr, res, ill,
                                     input logic [1:0] ext, input logic [3:0] alu,
                                     input logic [4:0] dst);
    return {j, b, bn, we, src, mw, mr, res, ill, ext, alu, dst};
  endfunction

  function automatic logic [19:0] ref_word(input logic [5:0] op, f, input logic [4:0] t, d);
    logic [19:0] w;
    case (op)
      6'b110000: w = mk(0,0,0,1,0,0,0,0,0, 2'b00, f[3:0],  d);
      6'b100000: w = mk(0,0,0,1,1,0,1,1,0, 2'b10, 4'b0100, t);
      6'b100001: w = mk(0,0,0,0,1,1,0,0,0, 2'b10, 4'b0100, 5'd0);
      6'b100010: w = mk(0,1,0,0,0,0,0,0,0, 2'b10, 4'b0101, 5'd0);
      6'b100011: w = mk(0,1,1,0,0,0,0,0,0, 2'b10, 4'b0101, 5'd0);
      6'b100100: w = mk(0,0,0,1,1,0,0,0,0, 2'b10, 4'b0100, t);
      6'b100101: w = mk(0,0,0,1,1,0,0,0,0, 2'b01, 4'b0000, t);
      6'b100110: w = mk(0,0,0,1,1,0,0,0,0, 2'b01, 4'b0001, t);
      6'b100111: w = mk(0,0,0,1,1,0,0,0,0, 2'b10, 4'b0111, t);
      6'b000000: w = mk(1,0,0,0,0,0,0,0,0, 2'b11, 4'b0000, 5'd0);
      6'b111111: w = '0;
      default:   w = mk(0,0,0,0,0,0,0,0,1, 2'b00, 4'b0000, 5'd0);
    endcase
    if (w[4:0] == 5'd0) w[16] = 1'b0;
    return w;
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  s, t, d;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[14];

  task automatic present(input logic [5:0] op, fn, input logic [4:0] s, t, d);
    opcode = op; fun = fn; rs = s; rt = t; rd = d; in_valid = 1'b1;
  endtask

  // Presents one instruction, waits (bounded) for in_ready, and lets it be accepted.
  task automatic issue(input logic [5:0] op, fn, input logic [4:0] s, t, d);
    int n;
    @(negedge clk);
    present(op, fn, s, t, d);
    out_ready = 1'b1;
    flush = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("issue_wait_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state: edge indices at which the multiply / load blocks clear.
  int          e, mul_free, ld_free;
  logic [4:0]  ld_reg;
  logic        m_valid;
  logic [19:0] m_word;

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    opcode = 6'b100100; fun = '0; rs = '0; rt = 5'd3; rd = '0;

    tbl[0]  = '{6'b100100, 6'd0,      5'd0, 5'd3,  5'd0,  mk(0,0,0,1,1,0,0,0,0,2'b10,4'b0100,5'd3)};
    tbl[1]  = '{6'b110000, 6'b000001, 5'd1, 5'd2,  5'd9,  mk(0,0,0,1,0,0,0,0,0,2'b00,4'b0001,5'd9)};
    tbl[2]  = '{6'b100000, 6'd0,      5'd1, 5'd5,  5'd0,  mk(0,0,0,1,1,0,1,1,0,2'b10,4'b0100,5'd5)};
    tbl[3]  = '{6'b100001, 6'd0,      5'd2, 5'd6,  5'd0,  mk(0,0,0,0,1,1,0,0,0,2'b10,4'b0100,5'd0)};
    tbl[4]  = '{6'b100010, 6'd0,      5'd1, 5'd2,  5'd0,  mk(0,1,0,0,0,0,0,0,0,2'b10,4'b0101,5'd0)};
    tbl[5]  = '{6'b100011, 6'd0,      5'd1, 5'd2,  5'd0,  mk(0,1,1,0,0,0,0,0,0,2'b10,4'b0101,5'd0)};
    tbl[6]  = '{6'b100101, 6'd0,      5'd1, 5'd4,  5'd0,  mk(0,0,0,1,1,0,0,0,0,2'b01,4'b0000,5'd4)};
    tbl[7]  = '{6'b100110, 6'd0,      5'd1, 5'd7,  5'd0,  mk(0,0,0,1,1,0,0,0,0,2'b01,4'b0001,5'd7)};
    tbl[8]  = '{6'b100111, 6'd0,      5'd1, 5'd8,  5'd0,  mk(0,0,0,1,1,0,0,0,0,2'b10,4'b0111,5'd8)};
    tbl[9]  = '{6'b000000, 6'd0,      5'd1, 5'd2,  5'd3,  mk(1,0,0,0,0,0,0,0,0,2'b11,4'b0000,5'd0)};
    tbl[10] = '{6'b111111, 6'd0,      5'd1, 5'd2,  5'd3,  20'd0};
    tbl[11] = '{6'b010101, 6'd0,      5'd1, 5'd2,  5'd3,  mk(0,0,0,0,0,0,0,0,1,2'b00,4'b0000,5'd0)};
    tbl[12] = '{6'b100100, 6'd0,      5'd1, 5'd0,  5'd0,  mk(0,0,0,0,1,0,0,0,0,2'b10,4'b0100,5'd0)};
    tbl[13] = '{6'b110000, 6'b000101, 5'd1, 5'd2,  5'd0,  mk(0,0,0,0,0,0,0,0,0,2'b00,4'b0101,5'd0)};

    // Reset behaviour
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_word", dut_word, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;

    // Decode table
    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].op, tbl[i].fn, tbl[i].s, tbl[i].t, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_word", i), dut_word, tbl[i].exp);
    end

    // Load-use: lw r5 then Rtype reading r5
    reset_dut();
    issue(6'b100000, 6'd0, 5'd0, 5'd5, 5'd0);
    @(negedge clk);
    present(6'b110000, 6'b000100, 5'd5, 5'd0, 5'd12);
    #1 chk("lu_stall_instage", in_ready, 0);
    @(negedge clk); #1 chk("lu_stall_gap", in_ready, 0);
    @(negedge clk); #1 chk("lu_release", in_ready, 1);
    @(posedge clk); #1 chk("lu_dest", dest_reg, 12);
    in_valid = 1'b0;

    // Multiply blocks issue for MUL_LAT-1 cycles
    reset_dut();
    issue(6'b110000, 6'b000110, 5'd0, 5'd0, 5'd10);
    @(negedge clk);
    present(6'b110000, 6'b000100, 5'd1, 5'd2, 5'd11);
    #1 chk("mul_block0", in_ready, 0);
    @(negedge clk); #1 chk("mul_block1", in_ready, 0);
    @(negedge clk); #1 chk("mul_release", in_ready, 1);
    @(posedge clk); #1 chk("mul_next_dest", dest_reg, 11);
    in_valid = 1'b0;

    // Hold ori under backpressure, then same-cycle transfer and reload
    reset_dut();
    issue(6'b100110, 6'd0, 5'd1, 5'd7, 5'd0);
    out_ready = 1'b0;
    present(6'b100100, 6'd0, 5'd1, 5'd3, 5'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("hold_word", dut_word, mk(0,0,0,1,1,0,0,0,0,2'b01,4'b0001,5'd7));
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("release_valid", out_valid, 1);
    chk("release_word", dut_word, mk(0,0,0,1,1,0,0,0,0,2'b10,4'b0100,5'd3));
    in_valid = 1'b0;

    // Flush right after a multiply is accepted
    reset_dut();
    issue(6'b110000, 6'b000110, 5'd0, 5'd0, 5'd10);
    @(negedge clk);
    present(6'b100100, 6'd0, 5'd1, 5'd9, 5'd0);
    flush = 1'b1; out_ready = 1'b0; #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    @(negedge clk);
    present(6'b100100, 6'd0, 5'd1, 5'd9, 5'd0);
    out_ready = 1'b1; #1;
    chk("flush_mul_cleared", in_ready, 1);
    @(posedge clk); #1;
    chk("flush_next_dest", dest_reg, 9);
    in_valid = 1'b0;

    // Randomized run against the reference model
    reset_dut();
    e = 0; mul_free = 0; ld_free = 0; ld_reg = '0; m_valid = 1'b0; m_word = '0;
    for (int c = 0; c < 2000; c++) begin
      logic [5:0] ops[12];
      logic       urs, urt, h_s, h_t, exp_rdy, acc, fire;
      ops = '{6'b110000, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
              6'b100101, 6'b100110, 6'b100111, 6'b000000, 6'b111111, 6'b010101};
      @(negedge clk);
      opcode    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      fun       = ($urandom_range(0, 3) == 0) ? 6'b000110 : 6'($urandom);
      rs        = 5'($urandom_range(0, 3));
      rt        = 5'($urandom_range(0, 3));
      rd        = 5'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      urs = !(opcode == 6'b000000 || opcode == 6'b111111);
      urt = (opcode == 6'b110000 || opcode == 6'b100001 ||
             opcode == 6'b100010 || opcode == 6'b100011);
      h_s = urs && rs != 0 && ((m_valid && m_word[13] && rs == m_word[4:0]) ||
                               (e < ld_free && rs == ld_reg));
      h_t = urt && rt != 0 && ((m_valid && m_word[13] && rt == m_word[4:0]) ||
                               (e < ld_free && rt == ld_reg));
      exp_rdy = !flush && (e >= mul_free) && !h_s && !h_t && (!m_valid || out_ready);
      chk("rnd_out_valid", out_valid, m_valid);
      if (m_valid) chk("rnd_word", dut_word, m_word);
      chk("rnd_in_ready", in_ready, exp_rdy);

      acc  = in_valid && exp_rdy;
      fire = m_valid && out_ready;
      if (flush) begin
        m_valid = 1'b0; mul_free = 0; ld_free = 0;
      end else begin
        if (fire && m_word[13]) begin
          ld_free = e + LOAD_GAP + 1;
          ld_reg  = m_word[4:0];
        end
        if (acc) begin
          m_valid = 1'b1;
          m_word  = ref_word(opcode, fun, rt, rd);
          if (opcode == 6'b110000 && fun == 6'b000110) mul_free = e + MUL_LAT;
        end else if (fire) begin
          m_valid = 1'b0;
        end
      end
      e++;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
